// File: rtl/bus_test_sequencer.sv
// Purpose: launches per-master bus commands with independent start offsets and hold windows, then waits for the masters to go idle.
// Latency: master i enables cmd_delay_i+1 cycles after start is accepted; DONE follows the first all-idle WAIT cycle.
// Backpressure: start is accepted only in IDLE; m_request holds the sequencer in WAIT (optional abort via SEQ_TIMEOUT_EN).
module bus_test_sequencer #(
    parameter int NUM_MASTERS    = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 14,
    parameter int HOLD_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_MASTERS-1:0]            cmd_en,
    input  logic [NUM_MASTERS-1:0]            cmd_read,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] cmd_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] cmd_data,
    input  logic [NUM_MASTERS*4-1:0]          cmd_delay,
    input  logic [NUM_MASTERS-1:0]            m_request,
    output logic [NUM_MASTERS-1:0]            m_enable,
    output logic [NUM_MASTERS-1:0]            m_read_en,
    output logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr_in,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] data_in,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout,
    output logic [1:0]                        state_out
);

    // Elaboration-time guard on the supported parameter ranges.
    if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("NUM_MASTERS must be 1..8");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("HOLD_CYCLES must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [4:0] HOLD5 = 5'(HOLD_CYCLES);

    state_t                          state;
    state_t                          state_nxt;
    logic                            start_acc;
    logic                            wait_abort;

    // Command snapshot taken on start acceptance; stays fixed for the whole run.
    logic [NUM_MASTERS-1:0]            lat_en;
    logic [NUM_MASTERS-1:0]            lat_read;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] lat_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] lat_data;
    logic [NUM_MASTERS*4-1:0]          lat_delay;

    // launch_cnt = cycles elapsed in LAUNCH; 5 bits covers 15 + 15 without wrap.
    logic [4:0]                      launch_cnt;
    logic [4:0]                      max_delay;
    logic                            launch_last;

    logic [NUM_MASTERS-1:0]            en_nxt;
    logic [NUM_MASTERS-1:0]            rd_nxt;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr_nxt;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] data_nxt;

    // Largest offset among enabled masters decides when the last window closes.
    always_comb begin
        max_delay = 5'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (lat_en[i] && ({1'b0, lat_delay[i*4 +: 4]} > max_delay)) begin
                max_delay = {1'b0, lat_delay[i*4 +: 4]};
            end
        end
    end

    assign launch_last = (launch_cnt == (max_delay + HOLD5));

    // Next-state logic; start is only looked at in IDLE, m_request only in WAIT.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = (|cmd_en) ? LAUNCH : DONE;
                end
            end
            LAUNCH: begin
                if (launch_last) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (m_request == '0) begin
                    state_nxt = DONE;
                end else if (wait_abort) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the command set when a start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_en    <= '0;
            lat_read  <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_delay <= '0;
        end else if (start_acc) begin
            lat_en    <= cmd_en;
            lat_read  <= cmd_read;
            lat_addr  <= cmd_addr;
            lat_data  <= cmd_data;
            lat_delay <= cmd_delay;
        end
    end

    // Launch counter: zeroed on acceptance, advances each LAUNCH cycle until the exit cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            launch_cnt <= 5'd0;
        end else if (start_acc) begin
            launch_cnt <= 5'd0;
        end else if ((state == LAUNCH) && !launch_last) begin
            launch_cnt <= launch_cnt + 5'd1;
        end
    end

    // Per-master window decode: master i is live while delay_i <= launch_cnt < delay_i + HOLD.
    always_comb begin
        en_nxt   = '0;
        rd_nxt   = '0;
        addr_nxt = '0;
        data_nxt = '0;
        if (state == LAUNCH) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (lat_en[i]
                    && (launch_cnt >= {1'b0, lat_delay[i*4 +: 4]})
                    && (launch_cnt < ({1'b0, lat_delay[i*4 +: 4]} + HOLD5))) begin
                    en_nxt[i]                        = 1'b1;
                    rd_nxt[i]                        = lat_read[i];
                    addr_nxt[i*ADDR_WIDTH +: ADDR_WIDTH] = lat_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = lat_read[i] ? '0
                                                         : lat_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Registered master-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_enable  <= '0;
            m_read_en <= '0;
            addr_in   <= '0;
            data_in   <= '0;
        end else begin
            m_enable  <= en_nxt;
            m_read_en <= rd_nxt;
            addr_in   <= addr_nxt;
            data_in   <= data_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        timeout_q;

    assign wait_abort = (state == WAIT) && (m_request != '0)
                        && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Counts consecutive busy WAIT cycles; any idle cycle or other state restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 16'd0;
        end else if ((state == WAIT) && (m_request != '0)) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= 16'd0;
        end
    end

    // Sticky abort flag: set on the abort transition, cleared by the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (start_acc) begin
            timeout_q <= 1'b0;
        end else if (wait_abort) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign wait_abort = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_out = state;

endmodule

// File: tb/tb_bus_test_sequencer.sv
// Purpose: directed-vector scoreboard bench for bus_test_sequencer (2 masters, HOLD 3, TIMEOUT 10).
// Latency: expected events carry absolute cycle numbers; the monitor samples on the falling edge.
// Backpressure: m_request is driven per test to hold or release the WAIT state.
module tb_bus_test_sequencer;

    localparam int NM   = 2;
    localparam int DW   = 8;
    localparam int AW   = 14;
    localparam int HOLD = 3;
    localparam int TMO  = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NM-1:0]     cmd_en;
    logic [NM-1:0]     cmd_read;
    logic [NM*AW-1:0]  cmd_addr;
    logic [NM*DW-1:0]  cmd_data;
    logic [NM*4-1:0]   cmd_delay;
    logic [NM-1:0]     m_request;
    logic [NM-1:0]     m_enable;
    logic [NM-1:0]     m_read_en;
    logic [NM*AW-1:0]  addr_in;
    logic [NM*DW-1:0]  data_in;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [1:0]        state_out;

    bus_test_sequencer #(
        .NUM_MASTERS   (NM),
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cmd_en   (cmd_en),
        .cmd_read (cmd_read),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cmd_delay(cmd_delay),
        .m_request(m_request),
        .m_enable (m_enable),
        .m_read_en(m_read_en),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [NM-1:0]     en;
        logic [NM-1:0]     rd;
        logic [NM*AW-1:0]  addr;
        logic [NM*DW-1:0]  data;
        logic              dn;
        logic              tmo;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic push(input int c, input logic [NM-1:0] en, input logic [NM-1:0] rd,
                        input logic [NM*AW-1:0] a, input logic [NM*DW-1:0] d,
                        input logic dn, input logic tmo);
        ev_t e;
        e.cyc = c; e.en = en; e.rd = rd; e.addr = a; e.data = d; e.dn = dn; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cyc %0d)", nm, got, want, cyc);
        end
    endtask

    // Monitor: every cycle with an enable or done present must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (((|m_enable) === 1'b1) || (done === 1'b1)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: cyc=%0d en=%b done=%b, want no event",
                         cyc, m_enable, done);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.en !== m_enable || e.rd !== m_read_en ||
                    e.addr !== addr_in || e.data !== data_in || e.dn !== done ||
                    e.tmo !== timeout) begin
                    n_bad++;
                    $display("FAIL event: got cyc=%0d en=%b rd=%b addr=%h data=%h done=%b tmo=%b, want cyc=%0d en=%b rd=%b addr=%h data=%h done=%b tmo=%b",
                             cyc, m_enable, m_read_en, addr_in, data_in, done, timeout,
                             e.cyc, e.en, e.rd, e.addr, e.data, e.dn, e.tmo);
                end
            end
        end
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Drive one command set with a single-cycle start pulse; returns the issue cycle.
    task automatic issue(input logic [NM-1:0] en, input logic [NM-1:0] rd,
                         input logic [NM*AW-1:0] a, input logic [NM*DW-1:0] d,
                         input logic [NM*4-1:0] dly, output int c);
        c         = cyc;
        cmd_en    = en;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_delay = dly;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1; start = 1'b0; cmd_en = '0; cmd_read = '0;
        cmd_addr = '0; cmd_data = '0; cmd_delay = '0; m_request = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 64'(state_out), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_tmo",   64'(timeout),   64'd0);
        chk("rst_outs",  64'({m_enable, m_read_en, addr_in, data_in}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // T1: master 0 write 1001/101, delay 0.
        c = cyc;
        for (int k = 2; k <= 4; k++) push(c + k, 2'b01, 2'b00, {14'd0, 14'd1001}, {8'd0, 8'd101}, 1'b0, 1'b0);
        push(c + 6, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0);
        issue(2'b01, 2'b00, {14'd0, 14'd1001}, {8'd0, 8'd101}, 8'h00, c);
        chk("t1_launch_state", 64'(state_out), 64'd1);
        chk("t1_launch_busy",  64'(busy),      64'd1);
        goto(c + 5);
        chk("t1_wait_state",   64'(state_out), 64'd2);
        goto(c + 7);
        chk("t1_idle_state",   64'(state_out), 64'd0);
        goto(c + 9);

        // T2: master 0 read 5097 delay 0, master 1 write 5098/103 delay 8.
        c = cyc;
        for (int k = 2; k <= 4; k++)   push(c + k, 2'b01, 2'b01, {14'd0, 14'd5097}, {8'd0, 8'd0}, 1'b0, 1'b0);
        for (int k = 10; k <= 12; k++) push(c + k, 2'b10, 2'b00, {14'd5098, 14'd0}, {8'd103, 8'd0}, 1'b0, 1'b0);
        push(c + 14, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0);
        issue(2'b11, 2'b01, {14'd5098, 14'd5097}, {8'd103, 8'd55}, {4'd8, 4'd0}, c);
        goto(c + 16);

        // T3: partially overlapping windows, delays 1 and 2.
        c = cyc;
        push(c + 3, 2'b01, 2'b00, {14'd0, 14'd100},   {8'd0, 8'd1}, 1'b0, 1'b0);
        push(c + 4, 2'b11, 2'b00, {14'd200, 14'd100}, {8'd2, 8'd1}, 1'b0, 1'b0);
        push(c + 5, 2'b11, 2'b00, {14'd200, 14'd100}, {8'd2, 8'd1}, 1'b0, 1'b0);
        push(c + 6, 2'b10, 2'b00, {14'd200, 14'd0},   {8'd2, 8'd0}, 1'b0, 1'b0);
        push(c + 8, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0);
        issue(2'b11, 2'b00, {14'd200, 14'd100}, {8'd2, 8'd1}, {4'd2, 4'd1}, c);
        goto(c + 10);

        // T4: no master enabled -> straight to DONE for one cycle.
        c = cyc;
        push(c + 1, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0);
        issue(2'b00, 2'b11, {14'd9, 14'd9}, {8'd9, 8'd9}, {4'd3, 4'd3}, c);
        goto(c + 2);
        chk("t4_back_idle", 64'(state_out), 64'd0);
        goto(c + 4);

        // T5: start re-issued mid-LAUNCH with different commands is ignored.
        c = cyc;
        for (int k = 4; k <= 6; k++) push(c + k, 2'b01, 2'b00, {14'd0, 14'd300}, {8'd0, 8'd30}, 1'b0, 1'b0);
        push(c + 8, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0);
        issue(2'b01, 2'b00, {14'd0, 14'd300}, {8'd0, 8'd30}, {4'd0, 4'd2}, c);
        goto(c + 2);
        cmd_en = 2'b11; cmd_read = 2'b11; cmd_addr = {14'd777, 14'd999}; cmd_delay = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        goto(c + 10);

        // T6: master 1 busy holds WAIT for 20 cycles.
        m_request = 2'b10;
        c = cyc;
        for (int k = 2; k <= 4; k++) push(c + k, 2'b10, 2'b00, {14'd7, 14'd0}, {8'd9, 8'd0}, 1'b0, 1'b0);
`ifdef SEQ_TIMEOUT_EN
        push(c + 15, 2'b00, 2'b00, '0, '0, 1'b1, 1'b1);
`else
        push(c + 25, 2'b00, 2'b00, '0, '0, 1'b1, 1'b0);
`endif
        issue(2'b10, 2'b00, {14'd7, 14'd0}, {8'd9, 8'd0}, {4'd0, 4'd0}, c);
        goto(c + 14);
        chk("t6_wait_hold", 64'(state_out), 64'd2);
        goto(c + 17);
`ifdef SEQ_TIMEOUT_EN
        chk("t6_tmo_sticky", 64'(timeout), 64'd1);
`else
        chk("t6_still_wait", 64'(state_out), 64'd2);
`endif
        goto(c + 24);
        m_request = 2'b00;
        goto(c + 27);

        // T7: reset in the second enable cycle, with start asserted on the same edge.
        c = cyc;
        push(c + 2, 2'b01, 2'b00, {14'd0, 14'd11}, {8'd0, 8'd22}, 1'b0, 1'b0);
        push(c + 3, 2'b01, 2'b00, {14'd0, 14'd11}, {8'd0, 8'd22}, 1'b0, 1'b0);
        issue(2'b01, 2'b00, {14'd0, 14'd11}, {8'd0, 8'd22}, {4'd0, 4'd0}, c);
        goto(c + 3);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("t7_rst_state", 64'(state_out), 64'd0);
        chk("t7_rst_busy",  64'(busy),      64'd0);
        chk("t7_rst_outs",  64'({m_enable, m_read_en, addr_in, data_in, done, timeout}), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        goto(c + 12);
        chk("t7_stay_idle", 64'(state_out), 64'd0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_test_sequencer.md
BUS_TEST_SEQUENCER -- requirements
Module: bus_test_sequencer

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of bus masters driven (1..8).
REQ-002 Parameter DATA_WIDTH, default 8: per-master write data width.
REQ-003 Parameter ADDR_WIDTH, default 14: per-master address width.
REQ-004 Parameter HOLD_CYCLES, default 3: cycles each launched master holds enable high (1..15).
REQ-005 Parameter TIMEOUT_CYCLES, default 255: WAIT-state abort limit (1..65535); used only with SEQ_TIMEOUT_EN.
REQ-006 One clock; reset is synchronous and active-high; the ports are named clk and reset.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  launch request, sampled only in IDLE.
REQ-010 cmd_en  in  NUM_MASTERS  per-master participate flag.
REQ-011 cmd_read  in  NUM_MASTERS  per-master read (1) or write (0).
REQ-012 cmd_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master address; master i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-013 cmd_data  in  NUM_MASTERS*DATA_WIDTH  per-master write data, packed as for cmd_addr.
REQ-014 cmd_delay  in  NUM_MASTERS*4  per-master launch offset in cycles (0..15).
REQ-015 m_request  in  NUM_MASTERS  master-busy indications from the masters.
REQ-016 m_enable, m_read_en  out  NUM_MASTERS each  registered per-master enable and read strobe.
REQ-017 addr_in, data_in  out  NUM_MASTERS*ADDR_WIDTH, NUM_MASTERS*DATA_WIDTH  registered per-master address and data.
REQ-018 busy, done, timeout  out  1 each; state_out  out  2  current state code.

Function
REQ-019 States: IDLE=0, LAUNCH=1, WAIT=2, DONE=3; state_out equals the current state code.
REQ-020 IDLE with start=1: latch every cmd_* input, clear launch counter; next state is LAUNCH, or DONE if cmd_en is all zero.
REQ-021 start in any state other than IDLE is ignored; latched commands stay fixed until the next IDLE acceptance.
REQ-022 Enabled master i: m_enable[i] rises exactly cmd_delay_i+1 cycles after the start-sampling edge and stays high for exactly HOLD_CYCLES cycles.
REQ-023 During that window, m_read_en[i] equals latched cmd_read_i and addr_in/data_in slice i carry the latched values; data slice is 0 when cmd_read_i=1.
REQ-024 Outside its window, and for any disabled master, all of master i's outputs are 0.
REQ-025 Windows of different masters may overlap fully or partially; each is timed independently.
REQ-026 LAUNCH exits to WAIT on the cycle after the last enabled window ends, i.e. the launch counter reaches max(enabled cmd_delay)+HOLD_CYCLES.
REQ-027 WAIT exits to DONE on the first cycle in which m_request is all zero; m_request is ignored in IDLE and LAUNCH.
REQ-028 DONE lasts exactly one cycle with done=1 and then returns to IDLE; done is 0 in all other states.
REQ-029 busy=1 in LAUNCH, WAIT and DONE, and 0 in IDLE.
REQ-030 Launch counter width is 5 bits and holds max 15+15=30 without wrap.

Reset
REQ-031 reset=1 at a clock edge forces IDLE and clears all counters, latches and outputs to 0 (m_enable, m_read_en, addr_in, data_in, busy, done, timeout, state_out); this applies mid-LAUNCH or mid-WAIT.
REQ-032 reset overrides start on the same edge; the first acceptance of start is the first edge after reset is low.

Configuration
REQ-033 With macro SEQ_TIMEOUT_EN defined, a 16-bit wait counter runs in WAIT; after TIMEOUT_CYCLES consecutive WAIT cycles with m_request non-zero, the block goes to DONE with timeout=1 during that DONE cycle.
REQ-034 timeout is cleared on the next start acceptance or on reset.
REQ-035 Without SEQ_TIMEOUT_EN, WAIT waits indefinitely, timeout is tied to 0, and no wait counter is built.

Verification
REQ-036 NUM_MASTERS=2; master 0 write, addr 1001, data 101, delay 0 -> m_enable[0] high on cycles 1-3 after start with addr_in0=1001 and data_in0=101; m_request=0 -> done on the cycle after WAIT.
REQ-037 Master 0 read addr 5097 delay 0 plus master 1 write addr 5098 data 103 delay 8 -> windows at cycles 1-3 and 9-11; m_read_en[0]=1 and data_in0=0.
REQ-038 cmd_en=0 with start pulse -> DONE immediately and one-cycle done; no m_enable activity.
REQ-039 m_request[1] held high 20 cycles into WAIT with SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=10 -> DONE with timeout=1 after 10 WAIT cycles; without the macro, exit only after m_request falls.
REQ-040 reset asserted in the second enable cycle -> all outputs 0 and state_out=0 on the next cycle; start re-issued mid-LAUNCH is ignored.
